// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t : responder FSM states
//   READ / WRITE : encoding of data_rw_i
//   WORD_W : data word width
package data_mem_responder_pkg;

    localparam int WORD_W = 32;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port synchronous RAM, 32-bit words, write enable, registered read.
// Kept as its own module so a vendor BRAM primitive can replace it.
// Ports:
//   clk   : clock
//   we    : write enable, mem[addr] <= wdata
//   re    : read enable, rdata <= mem[addr]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds between reads
module data_mem_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: accepts one word read/write request
// at a time, waits WAIT_CYCLES cycles, then completes it in a single RESP
// cycle. Out-of-range addresses complete with data_err_o and never touch RAM.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   data_address_i  : 30-bit word address
//   data_cs_i       : request valid
//   data_rw_i       : 0 read, 1 write
//   data_wdata_i    : write data
//   data_rdata_o    : read data, held until the next completed read
//   data_valid_o    : one-cycle completion pulse
//   data_ready_o    : request accepted this cycle if data_cs_i is high
//   data_err_o      : out-of-range flag, coincident with data_valid_o
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [29:0]       data_address_i,
    input  logic              data_cs_i,
    input  logic              data_rw_i,
    input  logic [WORD_W-1:0] data_wdata_i,
    output logic [WORD_W-1:0] data_rdata_o,
    output logic              data_valid_o,
    output logic              data_ready_o,
    output logic              data_err_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_rw;
    logic [WORD_W-1:0]     req_wdata;
    logic                  req_oor;
    logic                  resp_rd;     // current RESP is an in-range read
    logic [WORD_W-1:0]     rdata_hold;
    logic [WORD_W-1:0]     ram_q;

    logic                  in_oor;
    logic                  accept;
    logic                  enter_resp;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic                  cur_rw;
    logic [WORD_W-1:0]     cur_wdata;
    logic                  cur_oor;

    // Full 30-bit range check: any set bit above the index is out of range.
    assign in_oor = |data_address_i[29:DEPTH_LOG2];
    assign accept = (state == IDLE) && data_cs_i;

    // RAM access happens on the edge entering RESP. With zero wait that is
    // the acceptance edge itself, so the request comes straight from the
    // inputs; otherwise it comes from the capture registers.
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd1));

    assign cur_idx   = (state == IDLE) ? data_address_i[DEPTH_LOG2-1:0] : req_idx;
    assign cur_rw    = (state == IDLE) ? data_rw_i    : req_rw;
    assign cur_wdata = (state == IDLE) ? data_wdata_i : req_wdata;
    assign cur_oor   = (state == IDLE) ? in_oor       : req_oor;

    data_mem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (enter_resp && (cur_rw == WRITE) && !cur_oor),
        .re    (enter_resp && (cur_rw == READ)  && !cur_oor),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            req_idx      <= '0;
            req_rw       <= READ;
            req_wdata    <= '0;
            req_oor      <= 1'b0;
            resp_rd      <= 1'b0;
            rdata_hold   <= '0;
            data_ready_o <= 1'b1;
            data_valid_o <= 1'b0;
            data_err_o   <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            data_err_o   <= 1'b0;
            resp_rd      <= 1'b0;

            case (state)
                IDLE: begin
                    if (data_cs_i) begin
                        req_idx      <= data_address_i[DEPTH_LOG2-1:0];
                        req_rw       <= data_rw_i;
                        req_wdata    <= data_wdata_i;
                        req_oor      <= in_oor;
                        cnt          <= WAIT_INIT;
                        data_ready_o <= 1'b0;
                        state        <= (WAIT_INIT == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= RESP;
                end
                RESP: begin
                    state        <= IDLE;
                    data_ready_o <= 1'b1;
                    // Latch the read result so the output holds after RESP.
                    if (resp_rd) rdata_hold <= ram_q;
                end
                default: begin
                    state        <= IDLE;
                    data_ready_o <= 1'b1;
                end
            endcase

            if (enter_resp) begin
                data_valid_o <= 1'b1;
                data_err_o   <= cur_oor;
                resp_rd      <= (cur_rw == READ) && !cur_oor;
                // Out-of-range read returns zero and that zero is held.
                if ((cur_rw == READ) && cur_oor) rdata_hold <= '0;
            end
        end
    end

    // During an in-range read RESP the RAM register is the live data.
    assign data_rdata_o = (data_valid_o && resp_rd) ? ram_q : rdata_hold;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data-memory responder: the slave end of the CPU data port, after byte/halfword writes have been turned into word read-modify-write traffic. It accepts word read and word write requests on the 30-bit word address bus and serves them from an internal synchronous RAM. Access latency is programmable, and a ready/error handshake lets the upstream write-sync logic stall and detect bad addresses.

## Interface
Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; valid word addresses are 0 .. 2^DEPTH_LOG2-1.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset; asynchronous, active-high.
- data_address_i  input  30  word address of request.
- data_cs_i  input  1  request valid.
- data_rw_i  input  1  0 = read, 1 = write.
- data_wdata_i  input  32  write data, sampled at acceptance.
- data_rdata_o  output  32  read data, valid while data_valid_o = 1.
- data_valid_o  output  1  one-cycle pulse marking completion of an accepted request (read or write).
- data_ready_o  output  1  1 = a request is accepted this cycle if data_cs_i = 1.
- data_err_o  output  1  one-cycle pulse, coincident with data_valid_o, when the accepted address was out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - data_ready_o = 1.
  - If data_cs_i = 1 at posedge: capture address, rw and wdata; load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - data_ready_o = 0.
  - Counter decrements each cycle; on reaching 0, next state is RESP.
- RESP (exactly one cycle):
  - data_valid_o = 1, data_ready_o = 0.
  - Write: RAM[addr] <= wdata on the posedge entering RESP.
  - Read: data_rdata_o = RAM[addr].
  - Next state is IDLE.
- Out of range (address ≥ 2^DEPTH_LOG2):
  - Writes are dropped, with no RAM change.
  - data_rdata_o = 0 and data_err_o = 1 in RESP.
- data_rdata_o holds its value after RESP until the next completed read. Writes do not change it.
- Inputs are ignored outside IDLE. The requester must hold data_cs_i until it samples data_ready_o = 1.
- Address comparison uses the full 30 bits. The RAM is indexed by the low DEPTH_LOG2 bits only after the range check passes.

## Timing
- Reset values:
  - state = IDLE, data_ready_o = 1, data_valid_o = 0, data_err_o = 0, data_rdata_o = 0, counter = 0.
  - RAM contents are not cleared.
- Latency, acceptance edge to RESP cycle: WAIT_CYCLES + 1 clocks. Back-to-back throughput is one request per WAIT_CYCLES + 2 clocks.
- Write then read to the same address must return the new data. Ordering is guaranteed by serialisation.
- rst asserted mid-WAIT: the state returns to IDLE immediately and the pending request is discarded.
  - A pending write has not touched RAM and never does.
  - No data_valid_o is produced for the discarded request.
- data_cs_i held high continuously yields a new acceptance in each IDLE cycle following RESP.

## Structure
- A shared package holds:
  - the state enum (IDLE/WAIT/RESP);
  - localparams for the rw encoding (READ = 0, WRITE = 1);
  - the word width of 32.
- One sub-module, data_mem_ram: a single-port synchronous RAM (DEPTH_LOG2, 32-bit, write-enable, registered read). It is kept separate so it can be swapped for a BRAM primitive.
- The FSM, wait counter, request capture register and range check live in the top module.

## Test plan
- Write then read, WAIT_CYCLES = 1:
  - Write 0xDEADBEEF to addr 5, then read addr 5.
  - Expect data_valid_o 2 cycles after each acceptance, and data_rdata_o = 0xDEADBEEF.
- Ready gating, WAIT_CYCLES = 3:
  - Hold data_cs_i high with a read of addr 0.
  - Expect data_ready_o low for 4 cycles after acceptance, data_valid_o in cycle 4, and the next acceptance in cycle 5.
- Out of range, DEPTH_LOG2 = 10:
  - Write 0x12345678 to addr 1024, then read addr 1024.
  - Expect both responses with data_err_o = 1, and the read returns 0.
  - Addr 0 (the aliased index) remains unchanged.
- Reset mid-operation:
  - With WAIT_CYCLES = 2, write 0xAAAA5555 to addr 7, then assert rst during WAIT.
  - Expect no data_valid_o, all outputs at reset values, and a later read of addr 7 returning the pre-reset contents.
- Zero wait, WAIT_CYCLES = 0:
  - Alternate writes to addrs 0..3 (values 0x10..0x13), then read them back.
  - Expect a response every 2 cycles and data 0x10..0x13 in order.
- Read data hold:
  - Read addr 2 (0x12), then write 0x99 to addr 3.
  - data_rdata_o stays 0x12 through the write response.
